// File: rtl/mux_nx1_rr.sv
`default_nettype none
// ============================================================================
// mux_nx1_rr : N-to-1 byte-lane merger with per-channel FIFOs and RR/fixed arbiter
// Revision   : 1.0
// ============================================================================
module mux_nx1_rr #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in,
  input  logic [N-1:0]      valid,
  input  logic              rr_en,
  output logic [W-1:0]      out,
  output logic              validout,
  output logic [SELW-1:0]   sel,
  output logic [N-1:0]      full,
  output logic [N-1:0]      empty,
  output logic [N-1:0]      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [W-1:0]    mem    [N][DEPTH];
  logic [AW-1:0]   rd_ptr [N];
  logic [AW-1:0]   wr_ptr [N];
  logic [CW-1:0]   count  [N];
  logic [SELW-1:0] last;

  logic            grant;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] cand;
  logic [N-1:0]    pop;
  logic [N-1:0]    push_ok;

  for (genvar i = 0; i < N; i++) begin : g_flags
    assign empty[i] = (count[i] == '0);
    assign full[i]  = (count[i] == C_DEPTH);
  end

  // Round-robin starts the search one past the last grant; fixed priority from 0.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int j = 0; j < N; j++) begin
      cand = rr_en ? SELW'((int'(last) + 1 + j) % N) : SELW'(j);
      if (!grant && !empty[cand]) begin
        grant   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A full FIFO still accepts a push when it is drained in the same cycle.
  always_comb begin
    pop     = '0;
    push_ok = '0;
    for (int i = 0; i < N; i++) begin
      pop[i]     = grant && (gnt_idx == SELW'(i));
      push_ok[i] = valid[i] && (!full[i] || pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset && push_ok[i]) begin
        mem[i][wr_ptr[i]] <= in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      overflow <= '0;
      last     <= SELW'(N - 1);
      out      <= '0;
      validout <= 1'b0;
      sel      <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push_ok[i]) begin
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        if (push_ok[i] && !pop[i]) begin
          count[i] <= count[i] + CW'(1);
        end else if (!push_ok[i] && pop[i]) begin
          count[i] <= count[i] - CW'(1);
        end
        if (valid[i] && !push_ok[i]) begin
          overflow[i] <= 1'b1;
        end
      end
      validout <= grant;
      if (grant) begin
        out  <= mem[gnt_idx][rd_ptr[gnt_idx]];
        sel  <= gnt_idx;
        last <= gnt_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_rr.sv
`default_nettype none
// ============================================================================
// tb_mux_nx1_rr : scoreboard bench for mux_nx1_rr (N=4 instance plus N=2 instance)
// ============================================================================
module tb_mux_nx1_rr;

  localparam int N = 4, W = 8, DEPTH = 4, SELW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*W-1:0]    in;
  logic [N-1:0]      valid;
  logic              rr_en;
  logic [W-1:0]      out;
  logic              validout;
  logic [SELW-1:0]   sel;
  logic [N-1:0]      full, empty, overflow;

  logic [2*W-1:0]    in2;
  logic [1:0]        valid2;
  logic              rr_en2;
  logic [W-1:0]      out2;
  logic              validout2;
  logic [0:0]        sel2;
  logic [1:0]        full2, empty2, ovf2;

  int errors = 0;
  int checks = 0;

  logic [SELW+W-1:0] exp_q[$];
  logic [W:0]        exp2_q[$];
  logic [SELW+W-1:0] e1;
  logic [W:0]        e2;

  mux_nx1_rr #(.N(N), .W(W), .DEPTH(DEPTH), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .in(in), .valid(valid), .rr_en(rr_en),
    .out(out), .validout(validout), .sel(sel),
    .full(full), .empty(empty), .overflow(overflow)
  );

  mux_nx1_rr #(.N(2), .W(W), .DEPTH(4), .SELW(1)) dut2 (
    .clk(clk), .reset(reset), .in(in2), .valid(valid2), .rr_en(rr_en2),
    .out(out2), .validout(validout2), .sel(sel2),
    .full(full2), .empty(empty2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  // Scoreboards: every word the DUTs emit must be the next expected one.
  always @(negedge clk) begin
    if (validout === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out=%h sel=%0d, required no word", out, sel);
      end else begin
        e1 = exp_q.pop_front();
        if ({sel, out} !== e1) begin
          errors++;
          $display("FAIL sb_word: sel=%0d out=%h, required sel=%0d out=%h",
                   sel, out, e1[SELW+W-1:W], e1[W-1:0]);
        end
      end
    end
    if (validout2 === 1'b1) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL sb2_unexpected: out=%h sel=%0d, required no word", out2, sel2);
      end else begin
        e2 = exp2_q.pop_front();
        if ({sel2, out2} !== e2) begin
          errors++;
          $display("FAIL sb2_word: sel=%0d out=%h, required sel=%0d out=%h",
                   sel2, out2, e2[W], e2[W-1:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    valid  = '0;
    valid2 = '0;
    in     = '0;
    in2    = '0;
    cyc();
    cyc();
    reset = 1'b0;
    exp_q.delete();
    exp2_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c == 1) reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({out, validout, sel} !== {8'h00, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL reset_out[%0d]: out=%h validout=%b sel=%0d, required 00/0/0",
                 c, out, validout, sel);
      end
      checks++;
      if ({empty, full, overflow} !== {4'b1111, 4'b0000, 4'b0000}) begin
        errors++;
        $display("FAIL reset_flags[%0d]: empty=%b full=%b ovf=%b, required 1111/0000/0000",
                 c, empty, full, overflow);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    rr_en = 1'b1;
    in[2*W +: W] = 8'hA5;
    valid = 4'b0100;
    exp_q.push_back({2'd2, 8'hA5});
    cyc();
    valid = '0;
    @(negedge clk);
    checks++;
    if ({validout, empty[2]} !== 2'b00) begin
      errors++;
      $display("FAIL single_k: validout=%b empty2=%b, required 0/0", validout, empty[2]);
    end
    @(negedge clk);
    checks++;
    if ({validout, sel, out} !== {1'b1, 2'd2, 8'hA5}) begin
      errors++;
      $display("FAIL single_k1: v=%b sel=%0d out=%h, required 1/2/a5", validout, sel, out);
    end
    @(negedge clk);
    checks++;
    if ({validout, out, empty[2]} !== {1'b0, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_k2: v=%b out=%h empty2=%b, required 0/a5/1",
               validout, out, empty[2]);
    end
  endtask

  task automatic test_round_robin();
    int run;
    do_reset();
    rr_en = 1'b1;
    in    = {8'h30, 8'h00, 8'h20, 8'h10};
    valid = 4'b1011;
    exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd1, 8'h20});
    exp_q.push_back({2'd3, 8'h30}); exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h21}); exp_q.push_back({2'd3, 8'h31});
    cyc();
    in = {8'h31, 8'h00, 8'h21, 8'h11};
    cyc();
    valid = '0;
    run = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (validout === 1'b1) run++;
    end
    checks++;
    if (run != 6) begin
      errors++;
      $display("FAIL rr_burst: %0d valid cycles, required 6", run);
    end
    @(negedge clk);
    checks++;
    if (validout !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_end: validout=%b pending=%0d, required 0/0", validout, exp_q.size());
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    rr_en = 1'b0;
    in    = {8'h30, 8'h00, 8'h20, 8'h10};
    valid = 4'b1011;
    exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd0, 8'h11});
    exp_q.push_back({2'd1, 8'h20}); exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd3, 8'h30}); exp_q.push_back({2'd3, 8'h31});
    cyc();
    in = {8'h31, 8'h00, 8'h21, 8'h11};
    cyc();
    valid = '0;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fixed_drain: %0d words missing, required 0", exp_q.size());
    end
    // Switch to round-robin right after a ch1 grant: ch3 must be next.
    in    = {8'h50, 8'h00, 8'h40, 8'h00};
    valid = 4'b1010;
    exp_q.push_back({2'd1, 8'h40}); exp_q.push_back({2'd3, 8'h50});
    exp_q.push_back({2'd1, 8'h41}); exp_q.push_back({2'd3, 8'h51});
    cyc();
    in = {8'h51, 8'h00, 8'h41, 8'h00};
    cyc();
    valid = '0;
    rr_en = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_drain: %0d words missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    rr_en2 = 1'b0;
    for (int i = 1; i <= 6; i++) exp2_q.push_back({1'b0, 8'(i)});
    for (int i = 1; i <= 4; i++) exp2_q.push_back({1'b1, 8'(8'h80 + i)});
    for (int i = 1; i <= 6; i++) begin
      in2    = {8'(8'h80 + i), 8'(i)};
      valid2 = 2'b11;
      cyc();
      if (i == 4) begin
        checks++;
        if ({full2, ovf2} !== {2'b10, 2'b00}) begin
          errors++;
          $display("FAIL ovf_full: full=%b ovf=%b, required 10/00", full2, ovf2);
        end
      end
      if (i >= 5) begin
        checks++;
        if ({full2, ovf2} !== {2'b10, 2'b10}) begin
          errors++;
          $display("FAIL ovf_set[%0d]: full=%b ovf=%b, required 10/10", i, full2, ovf2);
        end
      end
    end
    valid2 = '0;
    for (int t = 0; t < 20 && exp2_q.size() != 0; t++) @(negedge clk);
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: %0d words missing, required 0", exp2_q.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ovf2, empty2, full2} !== {2'b10, 2'b11, 2'b00}) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b empty=%b full=%b, required 10/11/00",
               ovf2, empty2, full2);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (ovf2 !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b, required 00", ovf2);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    rr_en = 1'b1;
    in    = {8'h64, 8'h63, 8'h62, 8'h61};
    valid = 4'b1111;
    exp_q.push_back({2'd0, 8'h61});
    cyc();
    valid = '0;
    cyc();
    checks++;
    if ({validout, out} !== {1'b1, 8'h61}) begin
      errors++;
      $display("FAIL mid_pre: v=%b out=%h, required 1/61", validout, out);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out, validout, sel, empty, full, overflow} !==
        {8'h00, 1'b0, 2'd0, 4'b1111, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset: out=%h v=%b sel=%0d empty=%b full=%b ovf=%b, required 00/0/0/1111/0000/0000",
               out, validout, sel, empty, full, overflow);
    end
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (validout !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_discard: %0d stale words, %0d pending, required 0/0", seen, exp_q.size());
    end
  endtask

  initial begin
    reset  = 1'b1;
    in     = '0;
    valid  = '0;
    rr_en  = 1'b1;
    in2    = '0;
    valid2 = '0;
    rr_en2 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
